// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RV32I memory-access stage with req/ack data-memory port
//
// Purpose: takes the EX-stage record (ALU result, store data, op code, rd),
// performs loads/stores over a request/acknowledge data-memory port, stalls
// upstream while an access is outstanding and emits one write-back record
// (or an error pulse) per instruction.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ex_valid, ex_ctrl, ex_alu_c,  EX record: valid, {instr[30],funct3,opcode},
//   ex_rs2, ex_pc4, ex_rd         ALU result/address, store data, PC+4, rd
//   stall                         upstream must hold ex_* stable
//   dmem_req/we/addr/wdata/be     data-memory request (word address, lanes)
//   dmem_ack, dmem_rdata          completion and read word (same cycle)
//   wb_valid/we/rd/data           registered write-back record pulse
//   mem_err                       registered pulse: misaligned/illegal/timeout
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [10:0] ex_ctrl,
  input  logic [31:0] ex_alu_c,
  input  logic [31:0] ex_rs2,
  input  logic [31:0] ex_pc4,
  input  logic [4:0]  ex_rd,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        mem_err
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        is_load_q, is_load_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  rd_q, rd_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic [3:0]  dmem_be_q, dmem_be_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        mem_err_q, mem_err_d;

  // instr[30] has no meaning in this stage
  logic unused_ok;
  assign unused_ok = ex_ctrl[10];

  // ---------------------------------------------------------------------------
  // EX record decode
  // ---------------------------------------------------------------------------
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        is_load, is_store, is_branch, is_jump, is_mem;
  logic        legal, aligned, mem_ok;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  assign opc       = ex_ctrl[6:0];
  assign f3        = ex_ctrl[9:7];
  assign is_load   = (opc == OP_LOAD);
  assign is_store  = (opc == OP_STORE);
  assign is_branch = (opc == OP_BRANCH);
  assign is_jump   = (opc == OP_JAL) || (opc == OP_JALR);
  assign is_mem    = is_load || is_store;

  always_comb begin
    legal = 1'b0;
    if (is_load) begin
      legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
              (f3 == 3'b100) || (f3 == 3'b101);
    end else if (is_store) begin
      legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    end
  end

  // funct3[1:0] encodes access size for both loads and stores
  always_comb begin
    case (f3[1:0])
      2'b01:   aligned = (ex_alu_c[0] == 1'b0);
      2'b10:   aligned = (ex_alu_c[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  assign mem_ok = legal && aligned;

  always_comb begin
    case (f3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << ex_alu_c[1:0];
        st_wdata = {4{ex_rs2[7:0]}};
      end
      2'b01: begin
        st_be    = ex_alu_c[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{ex_rs2[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = ex_rs2;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load extraction from the returned word
  // ---------------------------------------------------------------------------
  logic [31:0] rd_shift;
  logic [31:0] ld_data;

  assign rd_shift = dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    case (f3_q[1:0])
      2'b00:   ld_data = f3_q[2] ? {24'h0, rd_shift[7:0]}
                                 : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   ld_data = f3_q[2] ? {16'h0, rd_shift[15:0]}
                                 : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: ld_data = dmem_rdata;
    endcase
  end

  // Counter value after this WAIT cycle equals TIMEOUT -> abort now, so the
  // registered mem_err lands TIMEOUT cycles after the request rose.
  logic timeout_hit;
  assign timeout_hit = (TIMEOUT != 0) && ((cnt_q + 32'd1) == 32'(TIMEOUT));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 32'd0;
      is_load_q    <= 1'b0;
      f3_q         <= 3'd0;
      off_q        <= 2'd0;
      rd_q         <= 5'd0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'd0;
      dmem_wdata_q <= 32'd0;
      dmem_be_q    <= 4'd0;
      wb_valid_q   <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_rd_q      <= 5'd0;
      wb_data_q    <= 32'd0;
      mem_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_load_q    <= is_load_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      rd_q         <= rd_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_be_q    <= dmem_be_d;
      wb_valid_q   <= wb_valid_d;
      wb_we_q      <= wb_we_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      mem_err_q    <= mem_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (ex_valid && is_mem && mem_ok) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // ack takes priority over a coincident timeout
        if (dmem_ack || timeout_hit) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    is_load_d    = is_load_q;
    f3_d         = f3_q;
    off_d        = off_q;
    rd_d         = rd_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_be_d    = dmem_be_q;
    wb_valid_d   = 1'b0;
    wb_we_d      = 1'b0;
    wb_rd_d      = 5'd0;
    wb_data_d    = 32'd0;
    mem_err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_we_d    = !is_branch && (ex_rd != 5'd0);
            wb_rd_d    = ex_rd;
            wb_data_d  = is_jump ? ex_pc4 : ex_alu_c;
          end else if (!mem_ok) begin
            mem_err_d = 1'b1;
          end else begin
            is_load_d    = is_load;
            f3_d         = f3;
            off_d        = ex_alu_c[1:0];
            rd_d         = ex_rd;
            dmem_we_d    = is_store;
            dmem_addr_d  = {ex_alu_c[31:2], 2'b00};
            dmem_wdata_d = is_store ? st_wdata : 32'd0;
            dmem_be_d    = is_store ? st_be : 4'b1111;
          end
        end
      end
      S_WAIT: begin
        if (dmem_ack) begin
          wb_valid_d = 1'b1;
          wb_we_d    = is_load_q && (rd_q != 5'd0);
          wb_rd_d    = rd_q;
          wb_data_d  = ld_data;
        end else if (timeout_hit) begin
          mem_err_d = 1'b1;
        end
        // clear the request fields so the port reads as zero while idle
        if (dmem_ack || timeout_hit) begin
          dmem_we_d    = 1'b0;
          dmem_addr_d  = 32'd0;
          dmem_wdata_d = 32'd0;
          dmem_be_d    = 4'd0;
        end
      end
      default: ;
    endcase
  end

  assign stall      = (state_q == S_WAIT);
  assign dmem_req   = (state_q == S_WAIT);
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign dmem_be    = dmem_be_q;
  assign wb_valid   = wb_valid_q;
  assign wb_we      = wb_we_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage
module tb_mem_access_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [10:0] ex_ctrl;
  logic [31:0] ex_alu_c, ex_rs2, ex_pc4;
  logic [4:0]  ex_rd;
  logic        stall, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_we, mem_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_alu_c(ex_alu_c), .ex_rs2(ex_rs2), .ex_pc4(ex_pc4), .ex_rd(ex_rd),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk_data;
    int          cyc;
  } exp_t;

  exp_t expq[$];
  exp_t e_m;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   stall_cnt = 0;
  int   req_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (stall) stall_cnt = stall_cnt + 1;
    if (dmem_req) req_cnt = req_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard whenever a record or error pulse appears
  always @(negedge clk) begin
    if (!rst && (wb_valid || mem_err)) begin
      if (expq.size() == 0) begin
        total = total + 1;
        bad = bad + 1;
        $display("FAIL unexpected_output wb_valid=%0d mem_err=%0d wb_data=%h cyc=%0d required=none",
                 wb_valid, mem_err, wb_data, cyc);
      end else begin
        e_m = expq.pop_front();
        chk("out_cycle", cyc, e_m.cyc);
        chk("mem_err", {31'd0, mem_err}, {31'd0, e_m.err});
        chk("wb_valid", {31'd0, wb_valid}, {31'd0, !e_m.err});
        if (!e_m.err) begin
          chk("wb_we", {31'd0, wb_we}, {31'd0, e_m.we});
          chk("wb_rd", {27'd0, wb_rd}, {27'd0, e_m.rd});
          if (e_m.chk_data) chk("wb_data", wb_data, e_m.data);
        end
      end
    end
  end

  task automatic push(input logic err, input logic we, input logic [4:0] rd,
                      input logic [31:0] d, input logic cd, input int c);
    exp_t e;
    e.err = err; e.we = we; e.rd = rd; e.data = d; e.chk_data = cd; e.cyc = c;
    expq.push_back(e);
  endtask

  task automatic drive(input logic [10:0] c, input logic [31:0] a, input logic [31:0] s,
                       input logic [31:0] p, input logic [4:0] r);
    ex_valid = 1'b1; ex_ctrl = c; ex_alu_c = a; ex_rs2 = s; ex_pc4 = p; ex_rd = r;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    chk({tag, "_req"}, {31'd0, dmem_req}, 32'd0);
    chk({tag, "_we"}, {31'd0, dmem_we}, 32'd0);
    chk({tag, "_addr"}, dmem_addr, 32'd0);
    chk({tag, "_wdata"}, dmem_wdata, 32'd0);
    chk({tag, "_be"}, {28'd0, dmem_be}, 32'd0);
    chk({tag, "_wb"}, {31'd0, wb_valid}, 32'd0);
    chk({tag, "_err"}, {31'd0, mem_err}, 32'd0);
  endtask

  // memory op with ack in the ack_at-th WAIT cycle
  task automatic mem_op(input string tag, input logic [10:0] c, input logic [31:0] a,
                        input logic [31:0] s, input logic [4:0] r, input int ack_at,
                        input logic [31:0] rdata, input logic exp_we, input logic [31:0] exp_d,
                        input logic chkd, input logic [31:0] eaddr, input logic [3:0] ebe,
                        input logic [31:0] ewdata, input logic ewe);
    stall_cnt = 0;
    drive(c, a, s, 32'h0, r);
    ex_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
    chk({tag, "_addr"}, dmem_addr, eaddr);
    chk({tag, "_be"}, {28'd0, dmem_be}, {28'd0, ebe});
    chk({tag, "_we"}, {31'd0, dmem_we}, {31'd0, ewe});
    if (ewe) chk({tag, "_wdata"}, dmem_wdata, ewdata);
    for (int k = 1; k <= ack_at; k++) begin
      if (k == ack_at) begin
        dmem_ack = 1'b1;
        dmem_rdata = rdata;
        push(1'b0, exp_we, r, exp_d, chkd, cyc + 1);
      end
      @(posedge clk); #1;
      dmem_ack = 1'b0;
    end
    @(negedge clk); #1;
    chk({tag, "_stall_cycles"}, stall_cnt, ack_at);
    chk({tag, "_req_after"}, {31'd0, dmem_req}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic err_op(input string tag, input logic [10:0] c, input logic [31:0] a);
    req_cnt = 0;
    stall_cnt = 0;
    push(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, cyc + 1);
    drive(c, a, 32'hDEADBEEF, 32'h0, 5'd9);
    ex_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk({tag, "_no_req"}, req_cnt, 0);
    chk({tag, "_no_stall"}, stall_cnt, 0);
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_ctrl = '0; ex_alu_c = '0; ex_rs2 = '0;
    ex_pc4 = '0; ex_rd = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk_zero_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    idle();

    // ALU ops: rd=5 writes, rd=0 does not, back-to-back retire one per cycle
    stall_cnt = 0;
    push(1'b0, 1'b1, 5'd5, 32'h0000000B, 1'b1, cyc + 1);
    drive(11'b0_000_0110011, 32'h0000000B, 32'h0, 32'h0, 5'd5);
    push(1'b0, 1'b0, 5'd0, 32'h0000000B, 1'b1, cyc + 1);
    drive(11'b0_000_0110011, 32'h0000000B, 32'h0, 32'h0, 5'd0);
    push(1'b0, 1'b1, 5'd12, 32'hCAFE0001, 1'b1, cyc + 1);
    drive(11'b1_000_0110011, 32'hCAFE0001, 32'h0, 32'h0, 5'd12);
    idle();
    idle();
    chk("alu_no_stall", stall_cnt, 0);

    // LB / LBU at 0x103, ack in third WAIT cycle
    mem_op("lb", 11'b0_000_0000011, 32'h00000103, 32'h0, 5'd6, 3, 32'h80FFFFFF,
           1'b1, 32'hFFFFFF80, 1'b1, 32'h00000100, 4'b1111, 32'h0, 1'b0);
    mem_op("lbu", 11'b0_100_0000011, 32'h00000103, 32'h0, 5'd6, 3, 32'h80FFFFFF,
           1'b1, 32'h00000080, 1'b1, 32'h00000100, 4'b1111, 32'h0, 1'b0);
    // LH upper half, sign extended; LW to rd=0 retires without write
    mem_op("lh", 11'b0_001_0000011, 32'h00000042, 32'h0, 5'd8, 1, 32'h80011234,
           1'b1, 32'hFFFF8001, 1'b1, 32'h00000040, 4'b1111, 32'h0, 1'b0);
    mem_op("lw_r0", 11'b0_010_0000011, 32'h00000080, 32'h0, 5'd0, 2, 32'h13572468,
           1'b0, 32'h13572468, 1'b1, 32'h00000080, 4'b1111, 32'h0, 1'b0);

    // stores
    mem_op("sh", 11'b0_001_0100011, 32'h00000202, 32'h1234ABCD, 5'd4, 1, 32'h0,
           1'b0, 32'h0, 1'b0, 32'h00000200, 4'b1100, 32'hABCDABCD, 1'b1);
    mem_op("sb", 11'b0_000_0100011, 32'h00000003, 32'h000000EF, 5'd4, 2, 32'h0,
           1'b0, 32'h0, 1'b0, 32'h00000000, 4'b1000, 32'hEFEFEFEF, 1'b1);
    mem_op("sw", 11'b0_010_0100011, 32'h00000010, 32'h89ABCDEF, 5'd4, 1, 32'h0,
           1'b0, 32'h0, 1'b0, 32'h00000010, 4'b1111, 32'h89ABCDEF, 1'b1);

    // misaligned / illegal
    err_op("lw_misaligned", 11'b0_010_0000011, 32'h00000101);
    err_op("sw_illegal_f3", 11'b0_011_0100011, 32'h00000100);

    // timeout: LW with no ack, then a stray ack, then a normal op
    req_cnt = 0;
    stall_cnt = 0;
    push(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, cyc + 1 + TO);
    drive(11'b0_010_0000011, 32'h00000200, 32'h0, 32'h0, 5'd3);
    ex_valid = 1'b0;
    repeat (TO) begin @(posedge clk); #1; end
    dmem_ack = 1'b1;
    dmem_rdata = 32'h55555555;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("timeout_req_cycles", req_cnt, TO);
    chk("timeout_stall_cycles", stall_cnt, TO);
    push(1'b0, 1'b1, 5'd2, 32'h00000077, 1'b1, cyc + 1);
    drive(11'b0_000_0010011, 32'h00000077, 32'h0, 32'h0, 5'd2);
    idle();

    // reset while waiting abandons the access; later ack is ignored
    drive(11'b0_010_0000011, 32'h00000300, 32'h0, 32'h0, 5'd7);
    ex_valid = 1'b0;
    @(negedge clk);
    chk("rstwait_req", {31'd0, dmem_req}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_zero_outputs("rstwait");
    @(posedge clk); #1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    idle();

    // JAL writes link value, branch writes nothing
    push(1'b0, 1'b1, 5'd1, 32'h00000048, 1'b1, cyc + 1);
    drive(11'b0_000_1101111, 32'h00001000, 32'h0, 32'h00000048, 5'd1);
    push(1'b0, 1'b0, 5'd3, 32'h0, 1'b0, cyc + 1);
    drive(11'b0_000_1100011, 32'h00000001, 32'h0, 32'h0, 5'd3);
    idle();
    repeat (3) idle();
    chk("queue_empty", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_expired actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access (MEM) stage of the 5-stage RV32I pipeline, directly downstream of the execute-stage ALU. It consumes the ALU result (address or arithmetic result), the store data and the 11-bit operation code, and performs LB/LH/LW/LBU/LHU/SB/SH/SW over a request/acknowledge data-memory port. It stalls the upstream stages while an access is outstanding and delivers one write-back record per instruction to the WB stage.

## Interface
- `TIMEOUT`, default 16: maximum cycles waiting for `dmem_ack` before aborting; 0 disables the timeout.
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ex_valid` in 1: EX record valid this cycle.
- `ex_ctrl` in 11: operation code; [10]=instr[30], [9:7]=funct3, [6:0]=opcode.
- `ex_alu_c` in 32: ALU result; effective address for loads/stores.
- `ex_rs2` in 32: store data.
- `ex_pc4` in 32: PC+4, the link value for JAL/JALR.
- `ex_rd` in 5: destination register.
- `stall` out 1: upstream must hold all `ex_*` inputs stable.
- `dmem_req` out 1: access request.
- `dmem_we` out 1: 1 = store.
- `dmem_addr` out 32: word address {addr[31:2],2'b00}.
- `dmem_wdata` out 32: lane-aligned store data.
- `dmem_be` out 4: byte enables.
- `dmem_ack` in 1: access complete; `dmem_rdata` is valid in the same cycle.
- `dmem_rdata` in 32: read word.
- `wb_valid` out 1: one-cycle pulse per retired record.
- `wb_we` out 1: register write enable.
- `wb_rd` out 5: destination register.
- `wb_data` out 32: write-back value.
- `mem_err` out 1: one-cycle pulse on a misaligned, illegal or timed-out access.

## Operation
- Opcode classes:
  - 0000011 = load.
  - 0100011 = store.
  - 1100011 = branch.
  - 1101111/1100111 = JAL/JALR.
  - Anything else = ALU op.
- FSM states are IDLE and WAIT. `stall` = (state==WAIT), decoded combinationally from the state register.
- IDLE, `ex_valid`=0: no action.
- IDLE, `ex_valid`=1, non-memory op:
  - Next cycle `wb_valid`=1 and `wb_rd`=`ex_rd`.
  - `wb_data` = `ex_pc4` for JAL/JALR, otherwise `ex_alu_c`.
  - `wb_we`=1 unless the op is a branch or `ex_rd`=0.
- IDLE, `ex_valid`=1, load/store, aligned and legal: latch ctrl, address, data and rd, then go to WAIT. `dmem_req`=1 from the next cycle.
- Alignment: halfword accesses need addr[0]=0; word accesses need addr[1:0]=0.
- Legal funct3 values: loads 000/001/010/100/101; stores 000/001/010.
- Misaligned or illegal access: no request is issued. Next cycle `mem_err`=1 and `wb_valid`=0. The FSM stays in IDLE.
- Store lanes:
  - SB: `dmem_be`=1<<addr[1:0]; `dmem_wdata`={4{rs2[7:0]}}.
  - SH: `dmem_be`=addr[1]?1100:0011; `dmem_wdata`={2{rs2[15:0]}}.
  - SW: `dmem_be`=1111; `dmem_wdata`=rs2.
- Loads: `dmem_be`=1111, `dmem_we`=0.
- Load extraction from `dmem_rdata` at offset addr[1:0]:
  - LB/LH: sign-extended.
  - LBU/LHU: zero-extended.
  - LW: whole word.
- WAIT:
  - `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata` and `dmem_be` are held constant.
  - The timeout counter increments each cycle.
  - `ex_valid` is ignored.
- WAIT and `dmem_ack`=1:
  - Go to IDLE; `dmem_req`=0 next cycle.
  - Next cycle `wb_valid`=1 with `wb_data` = the extracted load value.
  - `wb_we` = load && rd!=0. Stores produce `wb_valid`=1 with `wb_we`=0.
- WAIT, counter reaches `TIMEOUT`, and no ack: go to IDLE, `dmem_req`=0, `mem_err` pulse, no write-back. If ack and timeout occur in the same cycle, the ack wins.
- `dmem_ack` while in IDLE is ignored. A late ack arriving after a timeout or reset is discarded.

## Timing
- Reset values: state IDLE, counter 0, and every output 0 (`stall`, `dmem_*`, `wb_*`, `mem_err`).
- Reset asserted in WAIT abandons the transaction: `dmem_req`=0 on the following cycle and no write-back.
- Non-memory op accepted in cycle N: `wb_valid` at N+1, with `stall`=0 throughout. Back-to-back ALU ops retire one per cycle.
- Memory op accepted in cycle N:
  - `dmem_req` rises at N+1 and `stall`=1 from N+1.
  - If ack is sampled in cycle M≥N+1: `wb_valid` at M+1, `stall`=0 at M+1, and the next EX record is accepted at M+1.
  - Minimum occupancy is 2 cycles per memory op.
- Timeout: with no ack, `mem_err` is asserted at N+1+TIMEOUT and `stall` drops in the same cycle.
- `wb_*` and `mem_err` are registered and are single-cycle pulses.

## Test plan
- ALU op, `ex_ctrl`=00000110011, `ex_alu_c`=0x0000000B, rd=5 → next cycle `wb_valid`=1, `wb_we`=1, `wb_data`=0x0B, `stall` never asserted. Same op with rd=0 → `wb_we`=0.
- LB from addr 0x103, `dmem_rdata`=0x80FFFFFF, ack 3 cycles after req → `dmem_addr`=0x100, `stall` high 3 cycles, then `wb_data`=0xFFFFFF80. Repeat as LBU → 0x00000080.
- SH with rs2=0x1234ABCD, addr 0x202, immediate ack → `dmem_be`=1100, `dmem_wdata`=0xABCDABCD, `dmem_we`=1; `wb_valid`=1 with `wb_we`=0.
- LW at addr 0x101 → `mem_err` pulse at N+1, `dmem_req` never asserted, no write-back. SW with funct3=011 → same response.
- Timeout, `TIMEOUT`=4, LW and ack held at 0 → `mem_err` 5 cycles after accept, `dmem_req` falls, a later stray ack is ignored, and the next op is accepted normally.
- Reset in WAIT: `rst` for 1 cycle while `dmem_req`=1 → all outputs 0 next cycle, no `wb_valid`, a subsequent ack is ignored. JAL with `ex_pc4`=0x48 → `wb_data`=0x48.
